// File: rtl/mem_requester.sv
// Memory requester: turns core load/store commands into a valid/yumi memory handshake,
// with misalignment detection, a transaction timeout and byte-load formatting.
module mem_requester #(
  parameter int addr_width_p = 12,
  parameter int timeout_p    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_wen_i,
  input  logic                    cmd_byte_i,
  input  logic                    cmd_signed_i,
  input  logic [addr_width_p-1:0] cmd_addr_i,
  input  logic [31:0]             cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_data_o,
  output logic [1:0]              rsp_err_o,
  output logic [35:0]             mem_port_flat_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  input  logic [33:0]             mem_port_flat_i
);

  // Port structs; field order fixes the flattened bit layout (first field is the MSB).
  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        valid;
    logic [31:0] read_data;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    wen_q, byte_q, signed_q;
  logic [addr_width_p-1:0] addr_q;
  logic [31:0]             wdata_q;
  logic [7:0]              wait_q;
  logic [31:0]             rsp_data_q, rsp_data_d;
  logic [1:0]              rsp_err_q, rsp_err_d;
  logic [31:0]             load_data;
  logic                    accept;
  logic                    timeout_hit;
  mem_in_s                 mem_in;
  mem_out_s                mem_out;

  assign mem_out         = mem_port_flat_i;
  assign mem_port_flat_o = mem_in;

  assign cmd_ready_o = reset && (state_q == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign timeout_hit = (wait_q >= 8'(timeout_p - 1));

  always_comb begin
    if (wen_q)
      load_data = '0;
    else if (!byte_q)
      load_data = mem_out.read_data;
    else if (signed_q)
      load_data = {{24{mem_out.read_data[7]}}, mem_out.read_data[7:0]};
    else
      load_data = {24'b0, mem_out.read_data[7:0]};
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!cmd_byte_i && (cmd_addr_i[1:0] != 2'b00)) begin
            state_d    = DONE;
            rsp_data_d = '0;
            rsp_err_d  = 2'b01;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_out.yumi) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d    = DONE;
          rsp_data_d = '0;
          rsp_err_d  = 2'b10;
        end
      end
      RESP: begin
        if (mem_out.valid) begin
          state_d    = DONE;
          rsp_data_d = load_data;
          rsp_err_d  = 2'b00;
        end else if (timeout_hit) begin
          state_d    = DONE;
          rsp_data_d = '0;
          rsp_err_d  = 2'b10;
        end
      end
      DONE: begin
        if (rsp_ready_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The wait counter restarts whenever the state changes, so it measures time spent in REQ or RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == REQ || state_q == RESP) && !timeout_hit)
        wait_q <= wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q    <= cmd_wen_i;
      byte_q   <= cmd_byte_i;
      signed_q <= cmd_signed_i;
      addr_q   <= cmd_addr_i;
      wdata_q  <= cmd_wdata_i;
    end
  end

  // Responses arriving outside REQ are always acknowledged; only RESP keeps the data.
  always_comb begin
    mem_in.valid         = reset && (state_q == REQ);
    mem_in.wen           = wen_q;
    mem_in.byte_not_word = byte_q;
    mem_in.write_data    = wdata_q;
    mem_in.yumi          = reset && mem_out.valid && (state_q != REQ);
  end

  assign mem_addr_o  = addr_q;
  assign rsp_valid_o = reset && (state_q == DONE);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: directed scenarios plus randomized transactions
// against a byte-array reference model and a configurable stall/delay memory.
module tb_mem_requester;

  localparam int addr_width_p = 12;
  localparam int timeout_p    = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_wen_i = 1'b0;
  logic        cmd_byte_i = 1'b0;
  logic        cmd_signed_i = 1'b0;
  logic [11:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_err_o;
  logic [35:0] mem_port_flat_o;
  logic [11:0] mem_addr_o;
  logic [33:0] mem_port_flat_i;

  int check_count = 0;
  int fail_count  = 0;

  always #5 clk = ~clk;

  mem_requester #(.addr_width_p(addr_width_p), .timeout_p(timeout_p)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wen_i(cmd_wen_i),
    .cmd_byte_i(cmd_byte_i), .cmd_signed_i(cmd_signed_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .mem_port_flat_o(mem_port_flat_o),
    .mem_addr_o(mem_addr_o), .mem_port_flat_i(mem_port_flat_i)
  );

  // Memory side: yumi withheld for stall_cfg cycles, response delayed by delay_cfg cycles.
  logic        dut_mem_valid, dut_wen, dut_byte, dut_yumi;
  logic [31:0] dut_wdata;
  assign dut_mem_valid = mem_port_flat_o[35];
  assign dut_wen       = mem_port_flat_o[34];
  assign dut_byte      = mem_port_flat_o[33];
  assign dut_wdata     = mem_port_flat_o[32:1];
  assign dut_yumi      = mem_port_flat_o[0];

  logic [7:0]  mem_arr [0:4095] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:4095] = '{default: 8'h00};
  int          stall_cfg = 0;
  int          delay_cfg = 0;
  int          stall_cnt = 0;
  int          delay_cnt = 0;
  int          valid_cycles = 0;
  logic        m_pend = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        stray_valid = 1'b0;
  logic [31:0] stray_data = '0;
  logic        m_rvalid, m_yumi;

  assign m_rvalid = m_pend && (delay_cnt == 0);
  assign m_yumi   = dut_mem_valid && (stall_cnt >= stall_cfg);
  assign mem_port_flat_i = {m_rvalid | stray_valid, m_rvalid ? m_rdata : stray_data, m_yumi};

  always @(posedge clk) begin : mem_model
    int a;
    a = int'(mem_addr_o);
    if (dut_mem_valid) valid_cycles <= valid_cycles + 1;
    if (!dut_mem_valid) stall_cnt <= 0;
    else if (!m_yumi) stall_cnt <= stall_cnt + 1;
    if (m_rvalid && dut_yumi) m_pend <= 1'b0;
    else if (m_pend && delay_cnt > 0) delay_cnt <= delay_cnt - 1;
    if (dut_mem_valid && m_yumi) begin
      m_pend    <= 1'b1;
      delay_cnt <= delay_cfg;
      if (dut_wen) begin
        if (dut_byte) mem_arr[a] <= dut_wdata[7:0];
        else for (int i = 0; i < 4; i++) mem_arr[a+i] <= dut_wdata[8*i +: 8];
        m_rdata <= 32'h1234_5678;
      end else if (dut_byte) begin
        m_rdata <= {24'hA5C35A, mem_arr[a]};
      end else begin
        m_rdata <= {mem_arr[a+3], mem_arr[a+2], mem_arr[a+1], mem_arr[a]};
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: result and latency derived from the access rules, with a byte-array memory.
  task automatic refExec(input logic wen, input logic byt, input logic sgn, input logic [11:0] addr,
                         input logic [31:0] wdata, input int stall, input int delay,
                         output logic [31:0] data, output logic [1:0] err, output int lat);
    int a, b;
    a = int'(addr);
    data = 32'h0;
    if (!byt && (a % 4) != 0) begin
      err = 2'b01; lat = 1;
    end else if (stall >= timeout_p) begin
      err = 2'b10; lat = timeout_p + 1;
    end else begin
      err = 2'b00; lat = 3 + stall + delay;
      if (wen) begin
        if (byt) ref_mem[a] = wdata[7:0];
        else for (int i = 0; i < 4; i++) ref_mem[a+i] = wdata[8*i +: 8];
      end else if (byt) begin
        b = int'(ref_mem[a]);
        data = (sgn && b >= 128) ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
      end else begin
        data = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      end
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic byt, input logic sgn, input logic [11:0] addr,
                               input logic [31:0] wdata, input int stall, input int delay, input int hold);
    logic [31:0] exp_data, held_data;
    logic [1:0]  exp_err, held_err;
    int          exp_lat, lat, waited, vc0;
    refExec(wen, byt, sgn, addr, wdata, stall, delay, exp_data, exp_err, exp_lat);
    @(negedge clk);
    stall_cfg = stall; delay_cfg = delay;
    cmd_valid_i = 1'b1; cmd_wen_i = wen; cmd_byte_i = byt; cmd_signed_i = sgn;
    cmd_addr_i = addr; cmd_wdata_i = wdata;
    waited = 0;
    while (!cmd_ready_o && waited < 50) begin @(negedge clk); waited++; end
    checkOutput("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    if (!cmd_ready_o) begin cmd_valid_i = 1'b0; return; end
    vc0 = valid_cycles;
    @(posedge clk); lat = 1;
    @(negedge clk); cmd_valid_i = 1'b0;
    while (!rsp_valid_o && lat < 1000) begin @(posedge clk); lat++; @(negedge clk); end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    checkOutput("rsp_data", rsp_data_o, exp_data);
    if (exp_err == 2'b01) checkOutput("misaligned_no_mem_valid", 32'(valid_cycles - vc0), 32'd0);
    held_data = exp_data; held_err = exp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("hold_data", rsp_data_o, held_data);
      checkOutput("hold_err", 32'(rsp_err_o), 32'(held_err));
      checkOutput("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    checkOutput("done_cmd_ready", 32'(cmd_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk); rsp_ready_i = 1'b0;
    checkOutput("exit_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("exit_cmd_ready", 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin : main
    logic [11:0] ra;
    logic        rw, rb;
    // Reset behaviour.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_cmd_ready", 32'(cmd_ready_o), 32'd0);
    end
    checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset_mem_valid", 32'(dut_mem_valid), 32'd0);
    checkOutput("reset_rsp_data", rsp_data_o, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    reset = 1'b1;
    #1 checkOutput("post_reset_cmd_ready", 32'(cmd_ready_o), 32'd1);

    $display("[TB] directed word store/load");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, 0, 0);
    $display("[TB] directed byte store and signed/unsigned loads");
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h013, 32'h0000_0085, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h013, 32'h0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h013, 32'h0, 0, 0, 0);
    $display("[TB] misaligned word load");
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h012, 32'h0, 0, 0, 0);
    $display("[TB] timeout with withheld yumi, then late response in IDLE");
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h020, 32'h0, 300, 0, 0);
    @(negedge clk);
    stray_valid = 1'b1; stray_data = $urandom();
    #1 checkOutput("stray_yumi", 32'(dut_yumi), 32'd1);
    checkOutput("stray_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk); stray_valid = 1'b0;
    checkOutput("stray_rsp_valid", 32'(rsp_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, 0, 0);
    $display("[TB] response held in DONE");
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, 0, 10);

    $display("[TB] reset while in RESP");
    @(negedge clk);
    stall_cfg = 0; delay_cfg = 6;
    cmd_valid_i = 1'b1; cmd_wen_i = 1'b0; cmd_byte_i = 1'b0; cmd_addr_i = 12'h010;
    @(posedge clk);
    @(negedge clk); cmd_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_resp_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_resp_cmd_ready", 32'(cmd_ready_o), 32'd0);
    checkOutput("rst_resp_mem_valid", 32'(dut_mem_valid), 32'd0);
    checkOutput("rst_resp_yumi", 32'(dut_yumi), 32'd0);
    checkOutput("rst_resp_data", rsp_data_o, 32'd0);
    checkOutput("rst_resp_err", 32'(rsp_err_o), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_resp_ready_after", 32'(cmd_ready_o), 32'd1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, 0, 0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 24; n++) begin
      ra = 12'($urandom_range(0, 63));
      rw = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!rb && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      applyStimulus(rw, rb, 1'($urandom_range(0, 1)), ra, $urandom(),
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
